// File: rtl/pixel_pkg.sv
// ---------------------------------------------------------------------------
// pixel_pkg
// Shared definitions for the pixel_process slice: FSM state encoding, the
// pixel-pair record (two RGB pixels, six 8-bit channels), the channel
// maximum, and a helper that sizes index fields.
// ---------------------------------------------------------------------------
package pixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STARTUP = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_BLANK   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] g0;
        logic [7:0] b0;
        logic [7:0] r1;
        logic [7:0] g1;
        logic [7:0] b1;
    } pixel_pair_t;

    localparam logic [7:0] PIXEL_MAX = 8'd255;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_process_if.sv
// ---------------------------------------------------------------------------
// pixel_process_if
// Bus between pixel_process, the upstream frame memory and the downstream
// BMP writer.
//   rd_req/rd_row/rd_col : pair read request (master -> memory)
//   IN_*                 : pair data, valid one cycle after rd_req
//   HSYNC/DATA_WRITE_*   : processed pair and its valid strobe
//   VSYNC                : frame envelope
// Modports: master (pixel_process side), slave (environment side).
// ---------------------------------------------------------------------------
interface pixel_process_if
    import pixel_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
);
    localparam int ROW_W = idx_width(HEIGHT);
    localparam int COL_W = idx_width(WIDTH / 2);

    logic             rd_req;
    logic [ROW_W-1:0] rd_row;
    logic [COL_W-1:0] rd_col;
    logic [7:0]       IN_R0, IN_G0, IN_B0, IN_R1, IN_G1, IN_B1;
    logic             HSYNC;
    logic [7:0]       DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0;
    logic [7:0]       DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1;
    logic             VSYNC;

    modport master (
        output rd_req, rd_row, rd_col, HSYNC, VSYNC,
        output DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        output DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
        input  IN_R0, IN_G0, IN_B0, IN_R1, IN_G1, IN_B1
    );

    modport slave (
        input  rd_req, rd_row, rd_col, HSYNC, VSYNC,
        input  DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        input  DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
        output IN_R0, IN_G0, IN_B0, IN_R1, IN_G1, IN_B1
    );

endinterface

// File: rtl/pixel_adjust.sv
// ---------------------------------------------------------------------------
// pixel_adjust
// One channel of brightness adjustment: saturating add (SIGN=1) or subtract
// (SIGN=0) of VALUE, computed at 9 bits. With PIXEL_PROCESS_INVERT_EN defined
// the clamped result is inverted (255 - x). Purely combinational.
//   i_pix : input channel value
//   o_pix : adjusted channel value
// ---------------------------------------------------------------------------
module pixel_adjust
    import pixel_pkg::*;
#(
    parameter int VALUE = 100,
    parameter int SIGN  = 1
) (
    input  logic [7:0] i_pix,
    output logic [7:0] o_pix
);
    localparam logic [8:0] C_VALUE = {1'b0, VALUE[7:0]};
    localparam logic       C_ADD   = SIGN[0];

    logic [8:0] w_wide;
    logic [7:0] w_sat;

    // Widen, apply the offset, then clamp on carry-out / borrow.
    always_comb begin
        w_wide = 9'd0;
        w_sat  = 8'd0;
        if (C_ADD) begin
            w_wide = {1'b0, i_pix} + C_VALUE;
            if (w_wide[8]) begin
                w_sat = PIXEL_MAX;
            end else begin
                w_sat = w_wide[7:0];
            end
        end else begin
            w_wide = {1'b0, i_pix} - C_VALUE;
            if (w_wide[8]) begin
                w_sat = 8'd0;
            end else begin
                w_sat = w_wide[7:0];
            end
        end
    end

`ifdef PIXEL_PROCESS_INVERT_EN
    assign o_pix = PIXEL_MAX - w_sat;
`else
    assign o_pix = w_sat;
`endif

endmodule

// File: rtl/pixel_process.sv
// ---------------------------------------------------------------------------
// pixel_process
// Frame sequencer plus brightness data path. After a start pulse it waits
// START_DELAY cycles, then requests every pixel pair of a WIDTH x HEIGHT
// image row by row (HBLANK idle cycles between rows). Returned pairs are
// adjusted per channel and presented on HSYNC/DATA_WRITE_* two cycles after
// the request. ctrl_done is sticky until the next start.
// Ports:
//   HCLK, HRESET : clock, asynchronous active-high reset
//   start        : single-cycle frame start (honoured in IDLE and DONE)
//   ctrl_done    : frame complete
//   bus          : pixel_process_if.master (requests, pair in/out, VSYNC)
// Build option: PIXEL_PROCESS_INVERT_EN inverts every output channel.
// ---------------------------------------------------------------------------
module pixel_process
    import pixel_pkg::*;
#(
    parameter int WIDTH       = 768,
    parameter int HEIGHT      = 512,
    parameter int START_DELAY = 100,
    parameter int HBLANK      = 160,
    parameter int VALUE       = 100,
    parameter int SIGN        = 1
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             start,
    output logic             ctrl_done,
    pixel_process_if.master  bus
);
    localparam int ROW_W   = idx_width(HEIGHT);
    localparam int COL_W   = idx_width(WIDTH / 2);
    localparam int CNT_MAX = (START_DELAY > HBLANK) ? START_DELAY : HBLANK;
    localparam int CNT_W   = idx_width(CNT_MAX);

    localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(WIDTH / 2 - 1);
    localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] C_SD_LAST  = CNT_W'((START_DELAY > 1) ? START_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] C_HB_LAST  = CNT_W'((HBLANK > 1) ? HBLANK - 1 : 0);
    localparam bit               C_SD_ZERO  = (START_DELAY < 1);
    localparam bit               C_HB_ZERO  = (HBLANK < 1);

    state_t           r_state, w_state_nxt;
    logic [ROW_W-1:0] r_row, w_row_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic             w_rd_req_nxt, w_last_req, w_vsync_set, w_done_clr, w_start_ok;
    logic             r_rd_req, r_req_d1, r_last_d1, r_hsync, r_last_d2;
    logic             r_vsync, r_done;
    pixel_pair_t      r_data;
    logic [5:0][7:0]  w_in_ch, w_adj_ch;

    // A start in DONE is taken only once ctrl_done is up, so a pulse that
    // lands while the last pairs are still in the pipeline cannot be lost.
    assign w_start_ok = start && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && r_done));

    // State and counter registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, row/col and delay-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_state_nxt = C_SD_ZERO ? ST_ACTIVE : ST_STARTUP;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_STARTUP: begin
                if (r_cnt == C_SD_LAST) begin
                    w_state_nxt = ST_ACTIVE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (r_col == C_LAST_COL) begin
                    if (r_row == C_LAST_ROW) begin
                        w_state_nxt = ST_DONE;
                    end else if (C_HB_ZERO) begin
                        // No blanking: the next row follows back to back.
                        w_row_nxt = r_row + 1'b1;
                        w_col_nxt = '0;
                    end else begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_col_nxt = r_col + 1'b1;
                end
            end
            ST_BLANK: begin
                if (r_cnt == C_HB_LAST) begin
                    w_state_nxt = ST_ACTIVE;
                    w_row_nxt   = r_row + 1'b1;
                    w_col_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM-derived controls for the output registers.
    always_comb begin
        w_rd_req_nxt = (w_state_nxt == ST_ACTIVE);
        w_last_req   = (r_state == ST_ACTIVE) && (r_col == C_LAST_COL) && (r_row == C_LAST_ROW);
        w_done_clr   = (r_state == ST_DONE) && w_start_ok;
        case (r_state)
            ST_IDLE, ST_STARTUP, ST_DONE: w_vsync_set = (w_state_nxt == ST_ACTIVE);
            default:                      w_vsync_set = 1'b0;
        endcase
    end

    assign w_in_ch = {bus.IN_R0, bus.IN_G0, bus.IN_B0, bus.IN_R1, bus.IN_G1, bus.IN_B1};

    for (genvar g = 0; g < 6; g++) begin : g_adj
        pixel_adjust #(
            .VALUE (VALUE),
            .SIGN  (SIGN)
        ) u_adjust (
            .i_pix (w_in_ch[g]),
            .o_pix (w_adj_ch[g])
        );
    end

    // Request, pipeline and frame-status registers. r_req_d1 marks the cycle
    // the memory returns data; its registered copy is HSYNC.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_rd_req  <= 1'b0;
            r_req_d1  <= 1'b0;
            r_last_d1 <= 1'b0;
            r_hsync   <= 1'b0;
            r_last_d2 <= 1'b0;
            r_vsync   <= 1'b0;
            r_done    <= 1'b0;
            r_data    <= '0;
        end else begin
            r_rd_req  <= w_rd_req_nxt;
            r_req_d1  <= r_rd_req;
            r_last_d1 <= w_last_req;
            r_hsync   <= r_req_d1;
            r_last_d2 <= r_last_d1;
            if (r_req_d1) begin
                r_data <= pixel_pair_t'(w_adj_ch);
            end else begin
                r_data <= r_data;
            end
            // The last HSYNC of the frame drops VSYNC and raises ctrl_done.
            if (r_last_d2) begin
                r_vsync <= 1'b0;
            end else if (w_vsync_set) begin
                r_vsync <= 1'b1;
            end else begin
                r_vsync <= r_vsync;
            end
            if (r_last_d2) begin
                r_done <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end else begin
                r_done <= r_done;
            end
        end
    end

    assign bus.rd_req        = r_rd_req;
    assign bus.rd_row        = r_row;
    assign bus.rd_col        = r_col;
    assign bus.HSYNC         = r_hsync;
    assign bus.VSYNC         = r_vsync;
    assign bus.DATA_WRITE_R0 = r_data.r0;
    assign bus.DATA_WRITE_G0 = r_data.g0;
    assign bus.DATA_WRITE_B0 = r_data.b0;
    assign bus.DATA_WRITE_R1 = r_data.r1;
    assign bus.DATA_WRITE_G1 = r_data.g1;
    assign bus.DATA_WRITE_B1 = r_data.b1;
    assign ctrl_done         = r_done;

endmodule

// File: tb/tb_pixel_process.sv
// ---------------------------------------------------------------------------
// tb_pixel_process
// Three instances: A (8x2, delay 3, blank 2, +100), B (same, -100) and
// C (4x3, delay 1, no blanking, +100), all sharing start and reset. A small
// memory model answers each request from a table of hand-computed vectors.
// ---------------------------------------------------------------------------
module tb_pixel_process;
    import pixel_pkg::*;

    logic HCLK = 1'b0;
    logic HRESET;
    logic start;
    logic done_a, done_b, done_c;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    pixel_process_if #(.WIDTH(8), .HEIGHT(2)) ia ();
    pixel_process_if #(.WIDTH(8), .HEIGHT(2)) ib ();
    pixel_process_if #(.WIDTH(4), .HEIGHT(3)) ic ();

    pixel_process #(.WIDTH(8), .HEIGHT(2), .START_DELAY(3), .HBLANK(2), .VALUE(100), .SIGN(1))
        dut_a (.HCLK(HCLK), .HRESET(HRESET), .start(start), .ctrl_done(done_a), .bus(ia.master));
    pixel_process #(.WIDTH(8), .HEIGHT(2), .START_DELAY(3), .HBLANK(2), .VALUE(100), .SIGN(0))
        dut_b (.HCLK(HCLK), .HRESET(HRESET), .start(start), .ctrl_done(done_b), .bus(ib.master));
    pixel_process #(.WIDTH(4), .HEIGHT(3), .START_DELAY(1), .HBLANK(0), .VALUE(100), .SIGN(1))
        dut_c (.HCLK(HCLK), .HRESET(HRESET), .start(start), .ctrl_done(done_c), .bus(ic.master));

    typedef struct {
        pixel_pair_t pin;
        pixel_pair_t add;   // expected with +100
        pixel_pair_t sub;   // expected with -100
    } vec_t;
    vec_t tbl [8];

    // Expected output: inverted build returns 255 - x, which is ~x on 8 bits.
    function automatic pixel_pair_t exp_out(input pixel_pair_t v);
`ifdef PIXEL_PROCESS_INVERT_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    // Memory stand-ins: data one cycle after each request, junk otherwise.
    logic [47:0] mem_a, mem_b, mem_c;
    always @(posedge HCLK) begin
        mem_a <= ia.rd_req ? tbl[int'(ia.rd_row) * 4 + int'(ia.rd_col)].pin : {6{8'hEE}};
        mem_b <= ib.rd_req ? tbl[int'(ib.rd_row) * 4 + int'(ib.rd_col)].pin : {6{8'hEE}};
        mem_c <= ic.rd_req ? tbl[int'(ic.rd_row) * 2 + int'(ic.rd_col)].pin : {6{8'hEE}};
    end
    assign {ia.IN_R0, ia.IN_G0, ia.IN_B0, ia.IN_R1, ia.IN_G1, ia.IN_B1} = mem_a;
    assign {ib.IN_R0, ib.IN_G0, ib.IN_B0, ib.IN_R1, ib.IN_G1, ib.IN_B1} = mem_b;
    assign {ic.IN_R0, ic.IN_G0, ic.IN_B0, ic.IN_R1, ic.IN_G1, ic.IN_B1} = mem_c;

    pixel_pair_t dw_a, dw_b, dw_c;
    assign dw_a = {ia.DATA_WRITE_R0, ia.DATA_WRITE_G0, ia.DATA_WRITE_B0,
                   ia.DATA_WRITE_R1, ia.DATA_WRITE_G1, ia.DATA_WRITE_B1};
    assign dw_b = {ib.DATA_WRITE_R0, ib.DATA_WRITE_G0, ib.DATA_WRITE_B0,
                   ib.DATA_WRITE_R1, ib.DATA_WRITE_G1, ib.DATA_WRITE_B1};
    assign dw_c = {ic.DATA_WRITE_R0, ic.DATA_WRITE_G0, ic.DATA_WRITE_B0,
                   ic.DATA_WRITE_R1, ic.DATA_WRITE_G1, ic.DATA_WRITE_B1};

    // Event log filled by the monitor below.
    int          req_cyc_a[$], req_idx_a[$], hs_cyc_a[$];
    int          req_cyc_c[$], req_idx_c[$];
    pixel_pair_t hs_a[$], hs_b[$], hs_c[$];
    int          done_rise_a = -1, done_rise_c = -1, vs_rise_a = -1, vs_fall_a = -1;
    logic        prev_done_a = 1'b0, prev_done_c = 1'b0, prev_vs_a = 1'b0;
    logic        have_last = 1'b0;
    pixel_pair_t last_a;

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor on the falling edge; also checks DATA_WRITE holds between pulses.
    always @(negedge HCLK) begin
        if (HRESET) have_last = 1'b0;
        if (ia.rd_req) begin
            req_cyc_a.push_back(cyc);
            req_idx_a.push_back(int'(ia.rd_row) * 4 + int'(ia.rd_col));
        end
        if (ia.HSYNC) begin
            hs_cyc_a.push_back(cyc);
            hs_a.push_back(dw_a);
            last_a    = dw_a;
            have_last = 1'b1;
        end else if (have_last) begin
            chk($sformatf("hold_a@%0d", cyc), dw_a, last_a);
        end
        if (ib.HSYNC) hs_b.push_back(dw_b);
        if (ic.rd_req) begin
            req_cyc_c.push_back(cyc);
            req_idx_c.push_back(int'(ic.rd_row) * 2 + int'(ic.rd_col));
        end
        if (ic.HSYNC) hs_c.push_back(dw_c);
        if (done_a && !prev_done_a) done_rise_a = cyc;
        if (done_c && !prev_done_c) done_rise_c = cyc;
        if (ia.VSYNC && !prev_vs_a) vs_rise_a = cyc;
        if (!ia.VSYNC && prev_vs_a) vs_fall_a = cyc;
        prev_done_a = done_a;
        prev_done_c = done_c;
        prev_vs_a   = ia.VSYNC;
    end

    task automatic clear_log();
        req_cyc_a.delete(); req_idx_a.delete(); hs_cyc_a.delete();
        req_cyc_c.delete(); req_idx_c.delete();
        hs_a.delete(); hs_b.delete(); hs_c.delete();
        done_rise_a = -1; done_rise_c = -1; vs_rise_a = -1; vs_fall_a = -1;
    endtask

    task automatic pulse_start(output int s);
        @(posedge HCLK); #1;
        start = 1'b1;
        s     = cyc;
        @(posedge HCLK); #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for frame end, then checks the whole logged frame.
    task automatic check_frame(input int s);
        int exp_cyc;
        for (int k = 0; k < 200 && !done_a; k++) @(posedge HCLK);
        repeat (3) @(posedge HCLK);
        #1;
        chk("done_a_reached", done_a, 1);
        chk("req_count_a", req_cyc_a.size(), 8);
        chk("hs_count_a", hs_cyc_a.size(), 8);
        chk("hs_count_b", hs_b.size(), 8);
        chk("req_count_c", req_cyc_c.size(), 6);
        chk("hs_count_c", hs_c.size(), 6);
        if (req_cyc_a.size() == 8 && hs_cyc_a.size() == 8 && hs_b.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                exp_cyc = s + 4 + i + ((i >= 4) ? 2 : 0);
                chk($sformatf("req_cyc_a[%0d]", i), req_cyc_a[i], exp_cyc);
                chk($sformatf("req_idx_a[%0d]", i), req_idx_a[i], i);
                chk($sformatf("hs_cyc_a[%0d]", i), hs_cyc_a[i], exp_cyc + 2);
                chk($sformatf("data_a[%0d]", i), hs_a[i], exp_out(tbl[i].add));
                chk($sformatf("data_b[%0d]", i), hs_b[i], exp_out(tbl[i].sub));
            end
        end
        if (req_cyc_c.size() == 6 && hs_c.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("req_cyc_c[%0d]", i), req_cyc_c[i], s + 2 + i);
                chk($sformatf("req_idx_c[%0d]", i), req_idx_c[i], i);
                chk($sformatf("data_c[%0d]", i), hs_c[i], exp_out(tbl[i].add));
            end
        end
        chk("vsync_rise_a", vs_rise_a, s + 4);
        chk("vsync_fall_a", vs_fall_a, s + 16);
        chk("done_rise_a", done_rise_a, s + 16);
        chk("done_rise_c", done_rise_c, s + 10);
    endtask

    initial begin
        int s;
        int s_ign;

        //            input pair                              +100 result                              -100 result
        tbl[0] = '{{8'd200,8'd10,8'd50,8'd150,8'd0,8'd255},   {8'd255,8'd110,8'd150,8'd250,8'd100,8'd255}, {8'd100,8'd0,8'd0,8'd50,8'd0,8'd155}};
        tbl[1] = '{{8'd155,8'd156,8'd154,8'd100,8'd99,8'd101}, {8'd255,8'd255,8'd254,8'd200,8'd199,8'd201}, {8'd55,8'd56,8'd54,8'd0,8'd0,8'd1}};
        tbl[2] = '{{8'd10,8'd200,8'd150,8'd50,8'd255,8'd0},   {8'd110,8'd255,8'd250,8'd150,8'd255,8'd100}, {8'd0,8'd100,8'd50,8'd0,8'd155,8'd0}};
        tbl[3] = '{{8'd100,8'd101,8'd99,8'd154,8'd156,8'd155}, {8'd200,8'd201,8'd199,8'd254,8'd255,8'd255}, {8'd0,8'd1,8'd0,8'd54,8'd56,8'd55}};
        tbl[4] = '{{8'd0,8'd1,8'd2,8'd253,8'd254,8'd128},     {8'd100,8'd101,8'd102,8'd255,8'd255,8'd228}, {8'd0,8'd0,8'd0,8'd153,8'd154,8'd28}};
        tbl[5] = '{{8'd20,8'd40,8'd60,8'd80,8'd120,8'd140},   {8'd120,8'd140,8'd160,8'd180,8'd220,8'd240}, {8'd0,8'd0,8'd0,8'd0,8'd20,8'd40}};
        tbl[6] = '{{8'd160,8'd180,8'd200,8'd220,8'd240,8'd250}, {8'd255,8'd255,8'd255,8'd255,8'd255,8'd255}, {8'd60,8'd80,8'd100,8'd120,8'd140,8'd150}};
        tbl[7] = '{{8'd7,8'd77,8'd177,8'd207,8'd27,8'd127},   {8'd107,8'd177,8'd255,8'd255,8'd127,8'd227}, {8'd0,8'd0,8'd77,8'd107,8'd0,8'd27}};

        HRESET = 1'b1;
        start  = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_rd_req", ia.rd_req, 0);
        chk("rst_rd_row", ia.rd_row, 0);
        chk("rst_rd_col", ia.rd_col, 0);
        chk("rst_hsync", ia.HSYNC, 0);
        chk("rst_vsync", ia.VSYNC, 0);
        chk("rst_done", done_a, 0);
        chk("rst_data_a", dw_a, 0);
        chk("rst_data_b", dw_b, 0);
        #2 HRESET = 1'b0;
        repeat (2) @(posedge HCLK);
        clear_log();

        // Frame 1, with a start pulse during ACTIVE that must be ignored.
        pulse_start(s);
        repeat (3) @(posedge HCLK);
        pulse_start(s_ign);
        check_frame(s);

        // Start in DONE clears ctrl_done next cycle and runs frame 2.
        clear_log();
        pulse_start(s);
        chk("done_clear_a", done_a, 0);
        chk("done_clear_c", done_c, 0);
        check_frame(s);

        // Reset in the middle of row 1.
        clear_log();
        pulse_start(s);
        repeat (10) @(posedge HCLK);
        #2 HRESET = 1'b1;
        #1;
        chk("midrst_rd_req", ia.rd_req, 0);
        chk("midrst_rd_row", ia.rd_row, 0);
        chk("midrst_rd_col", ia.rd_col, 0);
        chk("midrst_hsync", ia.HSYNC, 0);
        chk("midrst_vsync", ia.VSYNC, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_data_a", dw_a, 0);
        repeat (2) @(posedge HCLK);
        #2 HRESET = 1'b0;
        clear_log();
        repeat (30) @(posedge HCLK);
        #1;
        chk("post_rst_req_a", req_cyc_a.size(), 0);
        chk("post_rst_hs_a", hs_cyc_a.size(), 0);
        chk("post_rst_hs_b", hs_b.size(), 0);
        chk("post_rst_done", done_a, 0);

        // A fresh start after reset yields a full frame.
        pulse_start(s);
        check_frame(s);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_process.md
PIXEL_PROCESS -- requirements
Module: pixel_process

Interface
REQ-001 Parameter WIDTH, default 768, image width in pixels; even.
REQ-002 Parameter HEIGHT, default 512, image height in rows.
REQ-003 Parameter START_DELAY, default 100, idle cycles between start and the first row request.
REQ-004 Parameter HBLANK, default 160, gap cycles between rows; 0 allowed.
REQ-005 Parameter VALUE, default 100, brightness offset, 0..255.
REQ-006 Parameter SIGN, default 1, 1 = add VALUE, 0 = subtract VALUE.
REQ-007 HCLK  in  1  clock; all state on rising edge.
REQ-008 HRESET  in  1  reset, asynchronous, active-high.
REQ-009 start  in  1  single-cycle frame start pulse.
REQ-010 rd_req  out  1  pixel-pair read request to upstream frame memory.
REQ-011 rd_row  out  $clog2(HEIGHT)  requested row, 0 = top.
REQ-012 rd_col  out  $clog2(WIDTH/2)  requested pair index within the row.
REQ-013 IN_R0, IN_G0, IN_B0, IN_R1, IN_G1, IN_B1  in  8 each  pair data; valid exactly one cycle after rd_req.
REQ-014 HSYNC  out  1  output pair valid, for the downstream BMP writer.
REQ-015 DATA_WRITE_R0, _G0, _B0, _R1, _G1, _B1  out  8 each  processed pair.
REQ-016 VSYNC  out  1  high from the first rd_req of a frame to the last HSYNC of that frame.
REQ-017 ctrl_done  out  1  frame complete, sticky.

Function
REQ-018 FSM states: IDLE, STARTUP, ACTIVE, BLANK, DONE.
REQ-019 IDLE: start moves to STARTUP; DONE: start clears ctrl_done and moves to STARTUP.
REQ-020 STARTUP waits exactly START_DELAY cycles, then moves to ACTIVE with row=0 and col=0.
REQ-021 ACTIVE asserts rd_req every cycle; col increments from 0 to WIDTH/2-1; at the last col it moves to BLANK, or to DONE if row==HEIGHT-1.
REQ-022 BLANK lasts HBLANK cycles, then increments row, clears col, and returns to ACTIVE; with HBLANK==0, ACTIVE continues to the next row with no gap.
REQ-023 A start received in STARTUP, ACTIVE or BLANK is ignored.
REQ-024 Data path: input registered once; HSYNC and DATA_WRITE_* are asserted 2 cycles after the corresponding rd_req.
REQ-025 Arithmetic is computed at 9-bit width; add saturates at 255, subtract saturates at 0; applied independently per channel.
REQ-026 DATA_WRITE_* hold their last value while HSYNC is low.
REQ-027 ctrl_done rises in the cycle of the last frame HSYNC plus 1, i.e. after WIDTH*HEIGHT/2 pairs (196608 at defaults).
REQ-028 VSYNC falls together with the rise of ctrl_done.

Reset
REQ-029 HRESET at any time, including mid-frame: FSM to IDLE; row and col cleared; delay counter cleared; in-flight pipeline data discarded.
REQ-030 Reset values: rd_req=0, rd_row=0, rd_col=0, HSYNC=0, VSYNC=0, ctrl_done=0, all DATA_WRITE_*=0.

Configuration
REQ-031 Macro PIXEL_PROCESS_INVERT_EN: when defined, each channel output is 255 minus the saturated result; latency is unchanged.
REQ-032 When PIXEL_PROCESS_INVERT_EN is undefined, the output is the saturated result and no inversion logic is present.

Structure
REQ-033 Shared package pixel_pkg holds the FSM state enum, the pixel_pair_t typedef (six 8-bit channels) and the 8-bit PIXEL_MAX constant.
REQ-034 Sub-module pixel_adjust contains the per-channel saturating add/subtract and optional inversion, instantiated six times; the FSM and counters stay in pixel_process.

Verification
REQ-035 WIDTH=8, HEIGHT=2, START_DELAY=3, HBLANK=2; start at cycle 0 -> first rd_req at cycle 4, 4 requests per row, 2-cycle gap between rows, 8 HSYNC pulses total, ctrl_done one cycle after the last HSYNC.
REQ-036 SIGN=1, VALUE=100; inputs 200 and 10 -> outputs 255 and 110. SIGN=0; inputs 50 and 150 -> outputs 0 and 50.
REQ-037 Macro defined, SIGN=1, VALUE=100, input 10 -> output 145; input 200 -> output 0.
REQ-038 HRESET pulsed mid-row 1 -> all outputs 0 asynchronously and no HSYNC after release; a fresh start then produces a full frame.
REQ-039 start pulsed during ACTIVE -> ignored; start in DONE -> ctrl_done clears next cycle and a second frame runs; HBLANK=0 -> continuous rd_req across the row boundary.
